// File: rtl/msrv32_dmem_ahb_slave_if.sv
// AHB-lite data-memory bus between the msrv32 store/load path and its memory responder.
// Signal names follow the responder's point of view.
interface msrv32_dmem_ahb_slave_if;
    logic [31:0] ms_riscv32_mp_dmaddr_in;
    logic [31:0] ms_riscv32_mp_dmdata_in;
    logic [3:0]  ms_riscv32_mp_dmwr_mask_in;
    logic        ms_riscv32_mp_dmwr_req_in;
    logic [1:0]  ahb_htrans_in;
    logic [31:0] ms_riscv32_mp_dmdata_out;
    logic        ahb_ready_out;
    logic        ahb_resp_out;

    modport master (
        output ms_riscv32_mp_dmaddr_in,
        output ms_riscv32_mp_dmdata_in,
        output ms_riscv32_mp_dmwr_mask_in,
        output ms_riscv32_mp_dmwr_req_in,
        output ahb_htrans_in,
        input  ms_riscv32_mp_dmdata_out,
        input  ahb_ready_out,
        input  ahb_resp_out
    );

    modport slave (
        input  ms_riscv32_mp_dmaddr_in,
        input  ms_riscv32_mp_dmdata_in,
        input  ms_riscv32_mp_dmwr_mask_in,
        input  ms_riscv32_mp_dmwr_req_in,
        input  ahb_htrans_in,
        output ms_riscv32_mp_dmdata_out,
        output ahb_ready_out,
        output ahb_resp_out
    );
endinterface

// File: rtl/msrv32_dmem_ahb_slave.sv
// AHB-lite data memory for msrv32: configurable wait states, byte-masked writes,
// two-cycle ERROR response for addresses outside the RAM window.
module msrv32_dmem_ahb_slave #(
    parameter int          ADDR_WIDTH  = 10,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                       ms_riscv32_mp_clk_in,
    input  logic                       ms_riscv32_mp_rst_in,
    msrv32_dmem_ahb_slave_if.slave     bus
);

    localparam int         DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    ready_d, resp_d;
    logic                    accept, in_range, commit;
    logic [ADDR_WIDTH-1:0]   idx_in;
    logic [ADDR_WIDTH-1:0]   widx_p0;
    logic                    wr_p0;
    logic [3:0]              mask_p0;
    logic                    vld_p0;
    logic [31:0]             rd_word, fwd_word;
    logic [31:0]             ram [0:DEPTH-1];
    logic                    unused_bits;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  mask);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) res[8*b +: 8] = new_w[8*b +: 8];
        end
        return res;
    endfunction

    assign unused_bits = ^{bus.ms_riscv32_mp_dmaddr_in[1:0], bus.ahb_htrans_in[0]};

    assign accept   = bus.ahb_htrans_in[1] && bus.ahb_ready_out;
    assign idx_in   = bus.ms_riscv32_mp_dmaddr_in[ADDR_WIDTH+1:2];
    assign in_range = (bus.ms_riscv32_mp_dmaddr_in[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    // Final OKAY data-phase cycle of a write: vld_p0 pending and no wait states left.
    assign commit   = vld_p0 && wr_p0 && (state_q == ST_IDLE);

    assign rd_word  = ram[idx_in];
    assign fwd_word = (commit && (widx_p0 == idx_in))
                    ? merge_bytes(rd_word, bus.ms_riscv32_mp_dmdata_in, mask_p0)
                    : rd_word;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
                if (accept) begin
                    if (!in_range) begin
                        state_d = ST_ERR1;
                    end else if (WS != 4'd0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WS;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE) || (state_d == ST_ERR2);
        resp_d  = (state_d == ST_ERR1) || (state_d == ST_ERR2);
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state_q                      <= ST_IDLE;
            cnt_q                        <= 4'd0;
            vld_p0                       <= 1'b0;
            bus.ahb_ready_out            <= 1'b1;
            bus.ahb_resp_out             <= 1'b0;
            bus.ms_riscv32_mp_dmdata_out <= 32'h0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            bus.ahb_ready_out <= ready_d;
            bus.ahb_resp_out  <= resp_d;
            if (accept) begin
                vld_p0                       <= in_range;
                bus.ms_riscv32_mp_dmdata_out <= in_range ? fwd_word : 32'h0;
            end else if (state_q == ST_IDLE) begin
                vld_p0 <= 1'b0;
            end
        end
    end

    // Address-phase capture (p0): consumed at the end of the data phase.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (accept) begin
            widx_p0 <= idx_in;
            wr_p0   <= bus.ms_riscv32_mp_dmwr_req_in;
            mask_p0 <= bus.ms_riscv32_mp_dmwr_mask_in;
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (mask_p0[b]) ram[widx_p0][8*b +: 8] <= bus.ms_riscv32_mp_dmdata_in[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_msrv32_dmem_ahb_slave.sv
// Directed bench: three responders (0, 1 and 3 wait states) share one clock, reset and
// address/data lines; only the selected one sees a NONSEQ transfer at a time.
module tb_msrv32_dmem_ahb_slave;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        wr;
    logic [1:0]  htr [3];
    int          cur;
    int          total;
    int          bad;
    logic        ready_sel, resp_sel;
    logic [31:0] rdata_sel;

    msrv32_dmem_ahb_slave_if if_ws0();
    msrv32_dmem_ahb_slave_if if_ws1();
    msrv32_dmem_ahb_slave_if if_ws3();

    assign if_ws0.ms_riscv32_mp_dmaddr_in    = addr;
    assign if_ws0.ms_riscv32_mp_dmdata_in    = wdata;
    assign if_ws0.ms_riscv32_mp_dmwr_mask_in = mask;
    assign if_ws0.ms_riscv32_mp_dmwr_req_in  = wr;
    assign if_ws0.ahb_htrans_in              = htr[0];
    assign if_ws1.ms_riscv32_mp_dmaddr_in    = addr;
    assign if_ws1.ms_riscv32_mp_dmdata_in    = wdata;
    assign if_ws1.ms_riscv32_mp_dmwr_mask_in = mask;
    assign if_ws1.ms_riscv32_mp_dmwr_req_in  = wr;
    assign if_ws1.ahb_htrans_in              = htr[1];
    assign if_ws3.ms_riscv32_mp_dmaddr_in    = addr;
    assign if_ws3.ms_riscv32_mp_dmdata_in    = wdata;
    assign if_ws3.ms_riscv32_mp_dmwr_mask_in = mask;
    assign if_ws3.ms_riscv32_mp_dmwr_req_in  = wr;
    assign if_ws3.ahb_htrans_in              = htr[2];

    msrv32_dmem_ahb_slave #(.ADDR_WIDTH(10), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_ws0 (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst), .bus(if_ws0.slave));
    msrv32_dmem_ahb_slave #(.ADDR_WIDTH(10), .WAIT_STATES(1), .BASE_ADDR(32'h0)) u_ws1 (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst), .bus(if_ws1.slave));
    msrv32_dmem_ahb_slave #(.ADDR_WIDTH(10), .WAIT_STATES(3), .BASE_ADDR(32'h0)) u_ws3 (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst), .bus(if_ws3.slave));

    assign ready_sel = (cur == 0) ? if_ws0.ahb_ready_out :
                       (cur == 1) ? if_ws1.ahb_ready_out : if_ws3.ahb_ready_out;
    assign resp_sel  = (cur == 0) ? if_ws0.ahb_resp_out :
                       (cur == 1) ? if_ws1.ahb_resp_out : if_ws3.ahb_resp_out;
    assign rdata_sel = (cur == 0) ? if_ws0.ms_riscv32_mp_dmdata_out :
                       (cur == 1) ? if_ws1.ms_riscv32_mp_dmdata_out : if_ws3.ms_riscv32_mp_dmdata_out;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One complete OKAY transfer on responder sel with ws wait states.
    task automatic xfer(input int sel, input int ws, input logic [31:0] a, input logic w,
                        input logic [3:0] m, input logic [31:0] d,
                        input logic chk_rd, input logic [31:0] exp_rd, input string tag);
        cur       = sel;
        addr      = a;
        wr        = w;
        mask      = m;
        wdata     = d;
        htr[sel]  = 2'b10;
        tick();
        htr[sel]  = 2'b00;
        for (int i = 0; i < ws; i++) begin
            chk({tag, "_wait_ready"}, {31'h0, ready_sel}, 32'h0);
            tick();
        end
        chk({tag, "_ready"}, {31'h0, ready_sel}, 32'h1);
        chk({tag, "_resp"}, {31'h0, resp_sel}, 32'h0);
        if (chk_rd) chk({tag, "_rdata"}, rdata_sel, exp_rd);
        tick();
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        cur    = 1;
        addr   = 32'h0;
        wdata  = 32'h0;
        mask   = 4'h0;
        wr     = 1'b0;
        htr[0] = 2'b00;
        htr[1] = 2'b00;
        htr[2] = 2'b00;
        rst    = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_ready", {31'h0, if_ws1.ahb_ready_out}, 32'h1);
        chk("rst_resp", {31'h0, if_ws1.ahb_resp_out}, 32'h0);
        chk("rst_rdata", if_ws1.ms_riscv32_mp_dmdata_out, 32'h0);
        @(negedge clk);
        tick();
        rst = 1'b0;
        tick();

        // Full-word write then read, one wait state
        xfer(1, 1, 32'h0000_0010, 1'b1, 4'hF, 32'hABCD_EF01, 1'b0, 32'h0, "w10_full");
        xfer(1, 1, 32'h0000_0010, 1'b0, 4'h0, 32'h0, 1'b1, 32'hABCD_EF01, "r10_full");
        xfer(1, 1, 32'h0000_0010, 1'b1, 4'hC, 32'h1234_0000, 1'b0, 32'h0, "w10_hi");
        xfer(1, 1, 32'h0000_0010, 1'b0, 4'h0, 32'h0, 1'b1, 32'h1234_EF01, "r10_hi");
        xfer(1, 1, 32'h0000_0010, 1'b1, 4'h0, 32'hFFFF_FFFF, 1'b0, 32'h0, "w10_nomask");
        xfer(1, 1, 32'h0000_0010, 1'b0, 4'h0, 32'h0, 1'b1, 32'h1234_EF01, "r10_nomask");

        // Zero wait states: write followed immediately by a read of the same word
        xfer(0, 0, 32'h0000_0020, 1'b1, 4'hF, 32'h1111_1111, 1'b0, 32'h0, "w20_init");
        cur    = 0;
        addr   = 32'h0000_0020;
        wr     = 1'b1;
        mask   = 4'h3;
        htr[0] = 2'b10;
        tick();
        chk("pipe_w_ready", {31'h0, ready_sel}, 32'h1);
        wdata  = 32'h0000_BEEF;
        wr     = 1'b0;
        mask   = 4'h0;
        tick();
        htr[0] = 2'b00;
        chk("pipe_r_ready", {31'h0, ready_sel}, 32'h1);
        chk("pipe_r_resp", {31'h0, resp_sel}, 32'h0);
        chk("pipe_r_fwd", rdata_sel, 32'h1111_BEEF);
        tick();
        xfer(0, 0, 32'h0000_0020, 1'b0, 4'h0, 32'h0, 1'b1, 32'h1111_BEEF, "r20_after");

        // Error response: the in-range alias of the same index must survive
        xfer(1, 1, 32'h0000_0678, 1'b1, 4'hF, 32'h5A5A_5A5A, 1'b0, 32'h0, "w678");
        cur    = 1;
        addr   = 32'h1234_5678;
        wr     = 1'b1;
        mask   = 4'h5;
        wdata  = 32'hFFFF_FFFF;
        htr[1] = 2'b10;
        tick();
        htr[1] = 2'b00;
        chk("errw_c1_ready", {31'h0, ready_sel}, 32'h0);
        chk("errw_c1_resp", {31'h0, resp_sel}, 32'h1);
        tick();
        chk("errw_c2_ready", {31'h0, ready_sel}, 32'h1);
        chk("errw_c2_resp", {31'h0, resp_sel}, 32'h1);
        tick();
        chk("errw_c3_ready", {31'h0, ready_sel}, 32'h1);
        chk("errw_c3_resp", {31'h0, resp_sel}, 32'h0);
        xfer(1, 1, 32'h0000_0678, 1'b0, 4'h0, 32'h0, 1'b1, 32'h5A5A_5A5A, "r678_after_err");
        xfer(1, 1, 32'h0000_0010, 1'b0, 4'h0, 32'h0, 1'b1, 32'h1234_EF01, "r10_after_err");
        addr   = 32'h1234_5678;
        wr     = 1'b0;
        htr[1] = 2'b10;
        tick();
        htr[1] = 2'b00;
        chk("errr_c1_resp", {31'h0, resp_sel}, 32'h1);
        tick();
        chk("errr_c2_ready", {31'h0, ready_sel}, 32'h1);
        chk("errr_c2_resp", {31'h0, resp_sel}, 32'h1);
        chk("errr_rdata", rdata_sel, 32'h0);
        tick();

        // IDLE and BUSY with a write request present
        addr  = 32'h0000_0010;
        wr    = 1'b1;
        mask  = 4'hF;
        wdata = 32'h0;
        for (int t = 0; t < 2; t++) begin
            htr[1] = 2'(t);
            tick();
            chk("idlebusy_ready_a", {31'h0, ready_sel}, 32'h1);
            chk("idlebusy_resp_a", {31'h0, resp_sel}, 32'h0);
            tick();
            chk("idlebusy_ready_b", {31'h0, ready_sel}, 32'h1);
        end
        htr[1] = 2'b00;
        xfer(1, 1, 32'h0000_0010, 1'b0, 4'h0, 32'h0, 1'b1, 32'h1234_EF01, "r10_after_idle");

        // Three wait states, then reset during the second wait cycle
        xfer(2, 3, 32'h0000_0030, 1'b1, 4'hF, 32'h0BAD_F00D, 1'b0, 32'h0, "w30_old");
        xfer(2, 3, 32'h0000_0030, 1'b0, 4'h0, 32'h0, 1'b1, 32'h0BAD_F00D, "r30_old");
        cur    = 2;
        addr   = 32'h0000_0030;
        wr     = 1'b1;
        mask   = 4'hF;
        wdata  = 32'hDEAD_BEEF;
        htr[2] = 2'b10;
        tick();
        htr[2] = 2'b00;
        chk("ws3_wait1_ready", {31'h0, ready_sel}, 32'h0);
        tick();
        chk("ws3_wait2_ready", {31'h0, ready_sel}, 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_ready", {31'h0, ready_sel}, 32'h1);
        chk("midrst_resp", {31'h0, resp_sel}, 32'h0);
        chk("midrst_rdata", rdata_sel, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        xfer(2, 3, 32'h0000_0030, 1'b0, 4'h0, 32'h0, 1'b1, 32'h0BAD_F00D, "r30_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
